// File: rtl/cr_kme_fifo_arb_pkg.sv
// Shared types and defaults for the KME FIFO write-port arbiter.
// Holds the FSM state enum, default sizes and the owner/pointer wrap helper.
package cr_kme_fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF        = 4;
  localparam int DATA_SIZE_DEF    = 611;
  localparam int LOCK_TIMEOUT_DEF = 255;
  localparam int GRANT_ID_W       = $clog2(N_REQ_DEF);

  // Requester index after idx, wrapping n-1 back to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cr_kme_rr_arb.sv
// Round-robin search: first set request at or above ptr, wrapping.
// Purely combinational; winner valid is low when no request is set.
module cr_kme_rr_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = $clog2(N_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          win_vld,
  output logic [IW-1:0] win_idx
);

  int j;

  // Scan N positions starting at ptr; keep the first hit.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!win_vld && req[IW'(j)]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// Packet-locking round-robin arbiter onto one KME FIFO write port.
// Define CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN to build the idle-lock watchdog.
module cr_kme_fifo_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int N_REQ        = N_REQ_DEF,
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][DATA_SIZE-1:0]  req_data,
  input  logic [N_REQ-1:0]                 req_eop,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [DATA_SIZE-1:0]             fifo_in,
  output logic                             fifo_in_valid,
  input  logic                             fifo_in_stall,
  output logic [$clog2(N_REQ)-1:0]         grant_id,
  output logic                             lock_timeout
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] gid_nxt;
  logic [IW-1:0] sel;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          acc;
  logic          sel_eop;

`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lto_nxt;
`endif

  cr_kme_rr_arb #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  // Grant the winner (idle) or the owner (locked) when the FIFO has room.
  always_comb begin
    req_ready = '0;
    sel       = (state == LOCKED) ? owner : win_idx;
    if (!rst && !fifo_in_stall) begin
      unique case (state)
        IDLE:   if (win_vld) req_ready[win_idx] = 1'b1;
        LOCKED: if (req_valid[owner]) req_ready[owner] = 1'b1;
        default: req_ready = '0;
      endcase
    end
  end

  assign acc           = |req_ready;
  assign fifo_in_valid = acc;
  assign fifo_in       = acc ? req_data[sel] : '0;
  assign sel_eop       = req_eop[sel];

  // Next state, owner, pointer and grant id.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    gid_nxt   = grant_id;
`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
    cnt_nxt   = cnt;
    lto_nxt   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
        cnt_nxt = '0;
`endif
        if (acc) begin
          gid_nxt = win_idx;
          if (sel_eop) begin
            rr_nxt = IW'(next_idx(int'(win_idx), N_REQ));
          end else begin
            state_nxt = LOCKED;
            owner_nxt = win_idx;
          end
        end
      end
      LOCKED: begin
        if (acc) begin
`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
          cnt_nxt = '0;
`endif
          if (sel_eop) begin
            state_nxt = IDLE;
            rr_nxt    = IW'(next_idx(int'(owner), N_REQ));
          end
        end
`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
        else if (!fifo_in_stall && !req_valid[owner]) begin
          if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            cnt_nxt   = '0;
            lto_nxt   = 1'b1;
            state_nxt = IDLE;
            rr_nxt    = IW'(next_idx(int'(owner), N_REQ));
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= gid_nxt;
    end
  end

`ifdef CR_KME_FIFO_ARB_LOCK_TIMEOUT_EN
  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      lock_timeout <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      lock_timeout <= lto_nxt;
    end
  end
`else
  assign lock_timeout = 1'b0;
`endif

endmodule
